// File: rtl/key_entry_buffer.sv
// key_entry_buffer: button synchronise/debounce, one-hot to BCD encoding and
// a 4-digit code accumulator that hands a complete code to the lock core with
// a one-cycle code_valid pulse.
module key_entry_buffer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [9:0]  din,
    input  logic        load,
    input  logic        sure,
    output logic [15:0] code,
    output logic [2:0]  digit_cnt,
    output logic        full,
    output logic        load_ack,
    output logic        digit_err,
    output logic        code_valid
);

    // The counter only has to reach DEBOUNCE_CYCLES-1: the flip happens on the
    // edge that would have made it DEBOUNCE_CYCLES.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button index 0 is load, index 1 is sure.
    logic [1:0]       btn_p0;
    logic [1:0]       btn_p1;
    logic [9:0]       din_p0;
    logic [9:0]       din_p1;
    logic [1:0]       deb;
    logic [1:0]       deb_q;
    logic [CNT_W-1:0] db_cnt [2];

    logic             clear_pend;
    logic             load_evt;
    logic             sure_evt;
    logic [15:0]      base_code;
    logic [2:0]       base_cnt;

    function automatic logic [3:0] to_bcd(input logic [9:0] d);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (d[k]) r = 4'(k);
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [9:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 10; k++) begin
            n = n + {3'b000, d[k]};
        end
        return (n == 4'd1);
    endfunction

    // Two-flop synchronisers for the raw buttons and the switch bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0 <= 2'b00;
            btn_p1 <= 2'b00;
            din_p0 <= 10'd0;
            din_p1 <= 10'd0;
        end else begin
            btn_p0 <= {sure, load};
            btn_p1 <= btn_p0;
            din_p0 <= din;
            din_p1 <= din_p0;
        end
    end

    // Per-button debounce: accept a new level after it has been stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb   <= 2'b00;
            deb_q <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (btn_p1[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    deb[i]    <= btn_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign load_evt = deb[0] & ~deb_q[0];
    assign sure_evt = deb[1] & ~deb_q[1];
    assign full     = (digit_cnt == 3'd4);

    // The buffer as seen this cycle: empty if the post-confirm clear is due now.
    always_comb begin
        base_code = code;
        base_cnt  = digit_cnt;
        if (clear_pend) begin
            base_code = 16'd0;
            base_cnt  = 3'd0;
        end
    end

    // Event handling with priority clr > sure > load; all pulses are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            code       <= 16'd0;
            digit_cnt  <= 3'd0;
            load_ack   <= 1'b0;
            digit_err  <= 1'b0;
            code_valid <= 1'b0;
            clear_pend <= 1'b0;
        end else begin
            load_ack   <= 1'b0;
            digit_err  <= 1'b0;
            code_valid <= 1'b0;
            clear_pend <= 1'b0;
            code       <= base_code;
            digit_cnt  <= base_cnt;
            if (clr) begin
                code      <= 16'd0;
                digit_cnt <= 3'd0;
            end else if (sure_evt) begin
                if (base_cnt == 3'd4) begin
                    code_valid <= 1'b1;
                    clear_pend <= 1'b1;
                end else begin
                    digit_err <= 1'b1;
                end
            end else if (load_evt) begin
                if (is_onehot(din_p1) && (base_cnt < 3'd4)) begin
                    code      <= {base_code[11:0], to_bcd(din_p1)};
                    digit_cnt <= base_cnt + 3'd1;
                    load_ack  <= 1'b1;
                end else begin
                    digit_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/key_entry_buffer.md
# key_entry_buffer

Front-end input stage for the digital lock. Synchronises and debounces the raw `load` and `sure` buttons, encodes the one-hot `din` switch bank to BCD, and accumulates a 4-digit code. On confirmation it presents the complete code to the lock core with a one-cycle valid pulse. The lock core consumes `code`/`code_valid` for both open and change-password operations instead of taking raw switch/button signals.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised cycles required before a button level is accepted. Board builds use 1_000_000.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset; clears every register, including synchronisers and debouncers.
- `clr` in 1: synchronous, active-high buffer clear (digits and count only).
- `din` in 10: one-hot digit switches; bit k = digit k.
- `load` in 1: raw digit-load button, asynchronous.
- `sure` in 1: raw confirm button, asynchronous.
- `code` out 16: four BCD digits; first-entered digit in [15:12], latest in [3:0].
- `digit_cnt` out 3: number of digits stored, 0..4.
- `full` out 1: level, high when `digit_cnt == 4`.
- `load_ack` out 1: one-cycle pulse, digit accepted.
- `digit_err` out 1: one-cycle pulse, input rejected.
- `code_valid` out 1: one-cycle pulse; `code` is the complete entry in that cycle.

## Operation
- **Reset:** all outputs 0; debounced levels 0; debounce counters 0.
- **Synchronisers:** `load`, `sure` and `din` each pass through 2 flip-flops.
- **Debounce (per button):**
  - A counter runs while the synchronised level differs from the debounced level; it is cleared whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A rising edge of the debounced level is a press event.
  - Pulses shorter than `DEBOUNCE_CYCLES` cycles produce no event.
- **Load event:**
  - Synchronised `din` has exactly one bit set and `digit_cnt < 4` → `code <= {code[11:0], bcd}`, `digit_cnt++`, `load_ack` pulses.
  - `din` is zero or has ≥2 bits set → `digit_err` pulses; `code` and `digit_cnt` unchanged.
  - `digit_cnt == 4` → `digit_err` pulses; nothing stored. There is no wrap-around.
- **Sure event:**
  - `full` → `code_valid` pulses with `code` unchanged during that cycle. On the next edge `code` becomes 0 and `digit_cnt` becomes 0.
  - Not full → `digit_err` pulses; buffer unchanged.
- **Priority within one cycle:** `rst` > `clr` > sure event > load event.
  - A load event coinciding with a sure event is discarded with no pulse.
  - An event coinciding with `clr` is discarded with no pulse.
- **`clr`:** zeroes `code` and `digit_cnt`. Debounce state is kept, so a held button does not re-fire after `clr` is released.
- **Mutual exclusion:** `load_ack`, `digit_err` and `code_valid` are never high in the same cycle.

## Timing
- Raw button edge to pulse (`load_ack`, `digit_err` or `code_valid`): exactly `DEBOUNCE_CYCLES + 3` rising edges after the first edge that samples the raw level high. Breakdown: 2 sync + `DEBOUNCE_CYCLES` count + 1 registered output.
- `code`, `digit_cnt` and `full` update on the same edge that raises `load_ack`.
- After `code_valid`, the buffer reads 0 one cycle later.
- Button release produces no event.
- A new press needs the debounced level to return low first, which takes `DEBOUNCE_CYCLES` stable-low cycles.
- `din` must be stable for 2 cycles before the load event; it is sampled only in the event cycle.
- `rst` or `clr` asserted mid-debounce:
  - `rst` aborts the pending event.
  - `clr` only discards an event landing in the same cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
1. **Four-digit entry and confirm.** Press `load` with `din` = 0x002, 0x004, 0x008, 0x010 in turn; hold each press for 10 cycles.
   - Each press: `load_ack` pulses 7 cycles after the press.
   - Final state: `code` = 0x1234, `full` = 1.
   - Press `sure`: `code_valid` pulses with `code` = 0x1234; next cycle `code` = 0, `digit_cnt` = 0.
2. **Invalid digit.** `din` = 0x003 or `din` = 0x000, then a `load` press → `digit_err` pulse; `digit_cnt` unchanged, no `load_ack`.
3. **Overflow and early confirm.**
   - 5th load after 4 digits → `digit_err`; `code` stays 0x1234.
   - `sure` with 2 digits stored → `digit_err`, no `code_valid`.
4. **Glitch rejection.** 2-cycle and 3-cycle pulses on `load` and on `sure` → no pulses of any kind. A 20-cycle hold → exactly one event.
5. **Clear mid-entry.** Enter 0x9, 0x8, then assert `clr` for 1 cycle → `code` = 0, `digit_cnt` = 0. Entering 0x7 next gives `code` = 0x0007.
6. **Reset mid-operation and simultaneous presses.**
   - Assert `rst` during a held `load` debounce → no event; all outputs 0.
   - `load` and `sure` pressed simultaneously with `full` set → only `code_valid`.
